// File: rtl/gal.sv
// ============================================================================
//  Module   : gal
//  Brief    : Programmable AND/OR array with macrocells and a serial config
//             loader. The GAL_CHECKSUM_EN macro enables the XOR checksum of
//             the configuration words.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module gal #(
    parameter int NUM_INPUTS  = 2,
    parameter int NUM_OUTPUTS = 1,
    parameter int NUM_TERMS   = 2,
    parameter int CFG_WORD_W  = 8
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   prog_start_i,
    input  logic                   cfg_valid_i,
    input  logic [CFG_WORD_W-1:0]  cfg_data_i,
    output logic                   cfg_ready_o,
    output logic                   configured_o,
    input  logic [NUM_INPUTS-1:0]  inputs_i,
    output logic [NUM_OUTPUTS-1:0] outputs_o,
    output logic [CFG_WORD_W-1:0]  checksum_o
);

    localparam int NUM_LITS  = NUM_INPUTS + NUM_OUTPUTS;
    localparam int TERM_W    = 2 * NUM_LITS;
    localparam int AND_BITS  = NUM_OUTPUTS * NUM_TERMS * TERM_W;
    localparam int CFG_BITS  = AND_BITS + 2 * NUM_OUTPUTS;
    localparam int NUM_WORDS = (CFG_BITS + CFG_WORD_W - 1) / CFG_WORD_W;
    localparam int CNT_W     = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

    typedef enum logic [1:0] {
        UNCONF = 2'd0,
        LOAD   = 2'd1,
        RUN    = 2'd2
    } state_t;

    state_t                 state;
    logic [CNT_W-1:0]       word_cnt;
    logic [CFG_BITS-1:0]    cfg;
    logic [CFG_BITS-1:0]    cfg_next;
    logic [NUM_OUTPUTS-1:0] q;
    logic [NUM_OUTPUTS-1:0] d;
    logic [NUM_OUTPUTS-1:0] mode;
    logic [NUM_LITS-1:0]    sig;
    logic [TERM_W-1:0]      lit;
    logic                   transfer;
    logic                   last_word;

    // Feedback is taken from the flip-flops only, so no configuration can
    // close a combinational loop.
    assign sig = {q, inputs_i};

    generate
        for (genvar s = 0; s < NUM_LITS; s++) begin : g_lit
            assign lit[2*s]   = sig[s];
            assign lit[2*s+1] = ~sig[s];
        end

        for (genvar m = 0; m < NUM_OUTPUTS; m++) begin : g_cell
            logic [NUM_TERMS-1:0] term;
            for (genvar p = 0; p < NUM_TERMS; p++) begin : g_term
                logic [TERM_W-1:0] mask;
                assign mask    = cfg[(m*NUM_TERMS+p)*TERM_W +: TERM_W];
                // An empty term is forced to 0 rather than the AND identity.
                assign term[p] = (|mask) & (&(lit | ~mask));
            end
            assign d[m]    = (|term) ^ cfg[AND_BITS + 2*m];
            assign mode[m] = cfg[AND_BITS + 2*m + 1];
        end
    endgenerate

    // Only bits that fall inside the current word are replaced; padding bits
    // of the final word have no destination and drop out naturally.
    always_comb begin
        cfg_next = cfg;
        for (int i = 0; i < CFG_BITS; i++) begin
            if (word_cnt == CNT_W'(i / CFG_WORD_W)) begin
                cfg_next[i] = cfg_data_i[i % CFG_WORD_W];
            end
        end
    end

    assign transfer  = (state == LOAD) && cfg_valid_i;
    assign last_word = (word_cnt == CNT_W'(NUM_WORDS - 1));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state    <= UNCONF;
            word_cnt <= '0;
            cfg      <= '0;
            q        <= '0;
        end else if (prog_start_i) begin
            state    <= LOAD;
            word_cnt <= '0;
            q        <= '0;
        end else begin
            case (state)
                LOAD: begin
                    if (transfer) begin
                        cfg <= cfg_next;
                        if (last_word) begin
                            state    <= RUN;
                            word_cnt <= '0;
                        end else begin
                            word_cnt <= word_cnt + 1'b1;
                        end
                    end
                end
                RUN:     q <= d;
                default: ;
            endcase
        end
    end

    assign cfg_ready_o  = (state == LOAD);
    assign configured_o = (state == RUN);
    assign outputs_o    = configured_o ? ((mode & q) | (~mode & d)) : '0;

`ifdef GAL_CHECKSUM_EN
    logic [CFG_WORD_W-1:0] checksum_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            checksum_q <= '0;
        end else if (prog_start_i) begin
            checksum_q <= '0;
        end else if (transfer) begin
            checksum_q <= checksum_q ^ cfg_data_i;
        end
    end

    assign checksum_o = checksum_q;
`else
    assign checksum_o = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_gal.sv
// ============================================================================
//  Module   : tb_gal
//  Brief    : Randomised and directed self-checking bench for gal against a
//             rule-level reference model.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_gal;

    localparam int N  = 2;
    localparam int M  = 1;
    localparam int P  = 2;
    localparam int W  = 8;
    localparam int L  = N + M;
    localparam int A  = M * P * 2 * L;
    localparam int CB = A + 2 * M;
    localparam int NW = (CB + W - 1) / W;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         prog_start = 1'b0;
    logic         cfg_valid = 1'b0;
    logic [W-1:0] cfg_data = '0;
    logic [N-1:0] inputs = '0;
    logic         cfg_ready;
    logic         configured;
    logic [M-1:0] outputs;
    logic [W-1:0] checksum;

    int tests = 0;
    int fails = 0;

    gal #(
        .NUM_INPUTS (N),
        .NUM_OUTPUTS(M),
        .NUM_TERMS  (P),
        .CFG_WORD_W (W)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .prog_start_i(prog_start),
        .cfg_valid_i (cfg_valid),
        .cfg_data_i  (cfg_data),
        .cfg_ready_o (cfg_ready),
        .configured_o(configured),
        .inputs_i    (inputs),
        .outputs_o   (outputs),
        .checksum_o  (checksum)
    );

    always #5 clk = ~clk;

    // Reference model: 0 = unconfigured, 1 = loading, 2 = running
    int           m_state = 0;
    int           m_cnt = 0;
    bit [CB-1:0]  m_cfg = '0;
    bit [M-1:0]   m_q = '0;
    bit [W-1:0]   m_chk = '0;
    bit [M-1:0]   m_nq;

    function automatic bit sig_val(int s);
        if (s < N) return inputs[s];
        return m_q[s-N];
    endfunction

    function automatic bit d_val(int m);
        bit sum = 0;
        for (int p = 0; p < P; p++) begin
            int  used = 0;
            bit  all  = 1;
            for (int l = 0; l < 2*L; l++) begin
                if (m_cfg[(m*P+p)*2*L + l]) begin
                    bit v = sig_val(l / 2);
                    used++;
                    if ((l % 2) == 1) v = !v;
                    if (!v) all = 0;
                end
            end
            if (used > 0 && all) sum = 1;
        end
        return sum ^ m_cfg[A + 2*m];
    endfunction

    function automatic logic [M-1:0] exp_out();
        logic [M-1:0] o = '0;
        if (m_state == 2) begin
            for (int m = 0; m < M; m++)
                o[m] = m_cfg[A + 2*m + 1] ? m_q[m] : d_val(m);
        end
        return o;
    endfunction

    function automatic logic [W-1:0] exp_chk();
`ifdef GAL_CHECKSUM_EN
        return m_chk;
`else
        return '0;
`endif
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_state = 0; m_cnt = 0; m_cfg = '0; m_q = '0; m_chk = '0;
        end else begin
            for (int m = 0; m < M; m++) m_nq[m] = d_val(m);
            if (prog_start) begin
                m_state = 1; m_cnt = 0; m_q = '0; m_chk = '0;
            end else if (m_state == 1 && cfg_valid) begin
                for (int j = 0; j < W; j++)
                    if (m_cnt*W + j < CB) m_cfg[m_cnt*W + j] = cfg_data[j];
                m_chk = m_chk ^ cfg_data;
                if (m_cnt == NW - 1) begin
                    m_state = 2; m_cnt = 0;
                end else begin
                    m_cnt++;
                end
            end else if (m_state == 2) begin
                m_q = m_nq;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            check("model_outputs",    32'(outputs),    32'(exp_out()));
            check("model_cfg_ready",  32'(cfg_ready),  32'(m_state == 1));
            check("model_configured", 32'(configured), 32'(m_state == 2));
            check("model_checksum",   32'(checksum),   32'(exp_chk()));
        end
    end

    task automatic drive(input bit ps, input bit v, input logic [W-1:0] d, input logic [N-1:0] in);
        @(posedge clk);
        #1;
        prog_start = ps;
        cfg_valid  = v;
        cfg_data   = d;
        inputs     = in;
    endtask

    initial begin
        #12;
        check("reset_outputs",    32'(outputs),    32'h0);
        check("reset_cfg_ready",  32'(cfg_ready),  32'h0);
        check("reset_configured", 32'(configured), 32'h0);
        check("reset_checksum",   32'(checksum),   32'h0);
        #1 rst_n = 1'b1;

        // Combinational AND: in0 & ~in1
        drive(1, 0, 8'h00, 2'b00);
        drive(0, 1, 8'h09, 2'b00);
        drive(0, 1, 8'h00, 2'b00);
        drive(0, 0, 8'h00, 2'b01);
        @(negedge clk);
        check("and_configured", 32'(configured), 32'h1);
        check("and_in01", 32'(outputs), 32'h1);
        drive(0, 0, 8'h00, 2'b11);
        @(negedge clk);
        check("and_in11", 32'(outputs), 32'h0);

        // Registered toggle: Q <= ~Q
        drive(1, 0, 8'h00, 2'b00);
        drive(0, 1, 8'h20, 2'b00);
        drive(0, 1, 8'h20, 2'b00);
        for (int k = 0; k < 4; k++) begin
            drive(0, 0, 8'h00, 2'b00);
            @(negedge clk);
            check("toggle_seq", 32'(outputs), 32'(k % 2));
        end

        // Backpressure then restart
        drive(1, 0, 8'h00, 2'b00);
        drive(0, 1, 8'h09, 2'b00);
        for (int k = 0; k < 3; k++) begin
            drive(0, 0, 8'h00, 2'b00);
            @(negedge clk);
            check("bp_ready", 32'(cfg_ready), 32'h1);
        end
        drive(1, 0, 8'h00, 2'b00);
        drive(0, 0, 8'h00, 2'b00);
        @(negedge clk);
        check("restart_ready", 32'(cfg_ready), 32'h1);
        drive(0, 1, 8'h09, 2'b01);
        @(negedge clk);
        check("restart_word0_conf", 32'(configured), 32'h0);
        drive(0, 1, 8'h00, 2'b01);
        @(negedge clk);
        check("restart_word1_conf", 32'(configured), 32'h0);
        drive(0, 0, 8'h00, 2'b01);
        @(negedge clk);
        check("restart_run", 32'(configured), 32'h1);

        // Start collides with final word
        drive(1, 0, 8'h00, 2'b00);
        drive(0, 1, 8'h09, 2'b00);
        drive(1, 1, 8'h00, 2'b00);
        drive(0, 0, 8'h00, 2'b00);
        @(negedge clk);
        check("collide_configured", 32'(configured), 32'h0);
        check("collide_ready", 32'(cfg_ready), 32'h1);

        // Async reset mid-RUN
        drive(0, 1, 8'h09, 2'b01);
        drive(0, 1, 8'h00, 2'b01);
        drive(0, 0, 8'h00, 2'b01);
        @(negedge clk);
        check("prereset_out", 32'(outputs), 32'h1);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_out",  32'(outputs),    32'h0);
        check("async_rst_conf", 32'(configured), 32'h0);
        #3 rst_n = 1'b1;

        // Checksum
        drive(1, 0, 8'h00, 2'b00);
        drive(0, 1, 8'h09, 2'b00);
        drive(0, 1, 8'h30, 2'b00);
        drive(0, 0, 8'h00, 2'b00);
        @(negedge clk);
`ifdef GAL_CHECKSUM_EN
        check("checksum_lit", 32'(checksum), 32'h39);
`else
        check("checksum_lit", 32'(checksum), 32'h00);
`endif

        // Random phase
        for (int k = 0; k < 600; k++) begin
            drive(($urandom % 25) == 0, $urandom % 2, W'($urandom), N'($urandom));
        end
        drive(0, 0, 8'h00, 2'b00);
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
